ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Latches the ID bundle and computes the ALU result through the existing `alu` module.
- Runs 32-bit signed/unsigned DIV/MOD on an iterative divider, and issues the data-SRAM request for loads/stores.
- Produces the EX→MEM bundle and the EX forwarding/stall information for ID.

Parameters:
- DIV_ITER, 32, number of divider iteration cycles (one quotient bit per cycle).

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- ID_to_EX_valid  in  1  ID bundle valid
- to_EX_data  in  `to_EX_data_width` (152)  {pc32, alu_op12, src1 32, src2 32, div_op4, res_from_mem1, mem_we1, rkd_value32, dest5, gr_we1}
- EX_allow_in  out  1  EX accepts a new bundle this cycle
- MEM_allow_in  in  1  MEM accepts
- EX_to_MEM_valid  out  1  bundle valid towards MEM
- to_MEM_data  out  `to_MEM_data_width` (71)  {pc32, alu_result32, res_from_mem1, dest5, gr_we1}
- data_sram_en  out  1  SRAM request enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  address = ALU result
- data_sram_wdata  out  32  rkd_value
- EX_forward  out  `forwrd_data_width` (37)  {dest masked by EX_valid, ex_result}
- EX_fwd_block  out  1  EX result not usable yet (load, or divide not done)

Behaviour:
- Handshake:
  - EX_allow_in = ~EX_valid | (EX_ready_go & MEM_allow_in).
  - EX_to_MEM_valid = EX_valid & EX_ready_go.
  - EX_valid loads ID_to_EX_valid whenever EX_allow_in.
  - Bundle register loads on ID_to_EX_valid & EX_allow_in; otherwise it holds.
- Reset (resetn low, async): EX_valid=0, bundle register=0, divider in IDLE, data_sram_en=0, data_sram_we=0, EX_fwd_block=0, EX_forward dest field=0.
- Non-divide ops: EX_ready_go=1, single-cycle.
  - ex_result = alu_result.
  - alu_op one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shift amounts use src2[4:0].
- Divide ops (div_op one-hot: div.w, mod.w, div.wu, mod.wu; any bit set = divide):
  - Divider FSM states: IDLE → BUSY → DONE.
  - IDLE → BUSY in the first cycle EX_valid & divide. Operands are converted to magnitudes and the sign flags recorded.
  - BUSY: one restoring step per cycle, DIV_ITER cycles, counter 5 bits.
  - BUSY → DONE when the counter reaches DIV_ITER-1. Quotient/remainder are sign-corrected and registered.
  - DONE: EX_ready_go=1, ex_result = quotient (div) or remainder (mod).
  - DONE → IDLE on the handoff cycle (EX_to_MEM_valid & MEM_allow_in).
  - Total: bundle enters at cycle k, result presented from cycle k+33.
  - Signed rules: quotient negative iff signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - Divide by zero completes in normal latency with quotient 0xFFFFFFFF and remainder = dividend.
  - EX_ready_go=0 in IDLE (entry cycle) and BUSY.
  - A divide followed back-to-back by a divide restarts correctly: the new bundle is latched on handoff and the FSM re-enters BUSY next cycle.
- Memory:
  - data_sram_en = EX_valid & (res_from_mem | mem_we) & MEM_allow_in.
  - data_sram_we = {4{EX_valid & mem_we & MEM_allow_in}}, so a request issues exactly once, on the handoff cycle.
  - Word access only; address bits [1:0] are passed through unchecked.
- Forwarding:
  - EX_forward = {dest & {5{EX_valid & gr_we}}, ex_result}.
  - EX_fwd_block = EX_valid & (res_from_mem | (divide & state≠DONE)).
- Mid-operation reset aborts any divide; the FSM returns to IDLE and no SRAM request is issued.

Decomposition:
- constants.h gains `to_EX_data_width` (152) and the alu_op/div_op bit-index macros.
- It reuses `to_MEM_data_width` (71) and `forwrd_data_width` (37).
- One sub-module: ex_divider (start, signed, dividend, divisor → busy, done, quotient, remainder, ack).
- The FSM and counter live in ex_divider; ex_stage holds the handshake and bundle logic.

Test Plan:
- add, src1=5, src2=7, MEM_allow_in=1 -> next cycle EX_to_MEM_valid=1, alu_result=12, EX_forward={dest, 12}, EX_fwd_block=0.
- div.w, src1=-7 (0xFFFFFFF9), src2=2 -> EX_allow_in=0 for 33 cycles; result 0xFFFFFFFD. Same operands with mod.w -> 0xFFFFFFFF.
- div.wu, src2=0, src1=0x1234 -> quotient 0xFFFFFFFF after 33 cycles; mod.wu -> 0x1234. div.w with 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Store, rkd=0xDEADBEEF, addr 0x100, MEM_allow_in=0 for 3 cycles then 1 -> data_sram_we=0xF asserted exactly one cycle, with addr 0x100 and wdata 0xDEADBEEF.
- Load in EX with dest=4 -> EX_fwd_block=1, EX_forward[36:32]=4. MEM_allow_in=0 holds the bundle unchanged with no SRAM request.
- resetn pulsed low at BUSY cycle 10 -> EX_valid=0 immediately (async). After release, an add completes normally in 1 cycle.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, opcode bit indices, divider state encodings,
// bundle layouts and small helpers for the execute stage.
package ex_stage_pkg;

  localparam int TO_EX_DATA_WIDTH  = 152;
  localparam int TO_MEM_DATA_WIDTH = 71;
  localparam int FORWRD_DATA_WIDTH = 37;

  localparam int ALU_OP_WIDTH = 12;
  localparam int DIV_OP_WIDTH = 4;

  // alu_op one-hot bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // div_op one-hot bit positions
  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  // Divider FSM encodings
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // ID -> EX bundle, MSB first
  typedef struct packed {
    logic [31:0]             pc;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [31:0]             src1;
    logic [31:0]             src2;
    logic [DIV_OP_WIDTH-1:0] div_op;
    logic                    res_from_mem;
    logic                    mem_we;
    logic [31:0]             rkd_value;
    logic [4:0]              dest;
    logic                    gr_we;
  } ex_bundle_t;

  // EX -> MEM bundle, MSB first
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic        gr_we;
  } mem_bundle_t;

  // Two's-complement negate when neg is set; used both for taking operand
  // magnitudes and for re-applying signs to the divider results.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: single-cycle integer ALU driven by a one-hot operation select.
// Ports: alu_op (one-hot select), alu_src1/alu_src2 (operands),
//        alu_result (selected result; zero when no op bit is set).
// Shifts use alu_src2[4:0]; lui passes alu_src2 (already positioned by ID).
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [31:0]             alu_src1,
  input  logic [31:0]             alu_src2,
  output logic [31:0]             alu_result
);

  logic [4:0]  shamt_s;
  logic [31:0] sra_s;
  logic        slt_s;
  logic        sltu_s;

  // Operation results merged with the one-hot select as an AND-OR mux
  always_comb begin
    shamt_s = alu_src2[4:0];
    sra_s   = $unsigned($signed(alu_src1) >>> shamt_s);
    slt_s   = $signed(alu_src1) < $signed(alu_src2);
    sltu_s  = alu_src1 < alu_src2;
    alu_result =
        ({32{alu_op[ALU_ADD]}}  & (alu_src1 + alu_src2))
      | ({32{alu_op[ALU_SUB]}}  & (alu_src1 - alu_src2))
      | ({32{alu_op[ALU_SLT]}}  & {31'd0, slt_s})
      | ({32{alu_op[ALU_SLTU]}} & {31'd0, sltu_s})
      | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
      | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
      | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
      | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
      | ({32{alu_op[ALU_SLL]}}  & (alu_src1 << shamt_s))
      | ({32{alu_op[ALU_SRL]}}  & (alu_src1 >> shamt_s))
      | ({32{alu_op[ALU_SRA]}}  & sra_s)
      | ({32{alu_op[ALU_LUI]}}  & alu_src2);
  end

endmodule

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring 32-bit divider, one quotient bit per cycle.
// Ports: clk/resetn, start (request, honoured only in IDLE), is_signed,
//        dividend/divisor (sampled on start), ack (result consumed),
//        busy/done (FSM status), quotient/remainder (valid while done).
// Operands are reduced to magnitudes at start; signs are re-applied on the
// final step so the DONE state presents registered, corrected results.
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dzero_q, dzero_d;

  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic [31:0] step_rem_s;
  logic [31:0] step_quo_s;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only when it does not borrow.
  always_comb begin
    shifted_s  = {rem_q, quo_q[31]};
    diff_s     = shifted_s - {1'b0, dvs_q};
    step_quo_s = {quo_q[30:0], ~diff_s[32]};
    if (diff_s[32]) begin
      step_rem_s = shifted_s[31:0];
    end else begin
      step_rem_s = diff_s[31:0];
    end
  end

  // Divider FSM next state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzero_d = dzero_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_BUSY;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = magnitude(dividend, is_signed & dividend[31]);
          dvs_d   = magnitude(divisor, is_signed & divisor[31]);
          qneg_d  = is_signed & (dividend[31] ^ divisor[31]);
          rneg_d  = is_signed & dividend[31];
          dzero_d = (divisor == 32'd0);
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          // Divide by zero reports all-ones regardless of signedness.
          state_d = DIV_DONE;
          quo_d   = dzero_q ? 32'hFFFF_FFFF : magnitude(step_quo_s, qneg_q);
          rem_d   = magnitude(step_rem_s, rneg_q);
        end else begin
          quo_d = step_quo_s;
          rem_d = step_rem_s;
        end
      end
      DIV_DONE: begin
        if (ack) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_DONE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // Divider state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dzero_q <= dzero_d;
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID and MEM.
// Ports: clk/resetn; ID_to_EX_valid/to_EX_data (ID bundle in);
//        EX_allow_in (back-pressure to ID); MEM_allow_in (back-pressure in);
//        EX_to_MEM_valid/to_MEM_data (bundle out); data_sram_* (data SRAM
//        request); EX_forward/EX_fwd_block (bypass info for ID).
// Non-divide ops finish in one cycle through alu; divides hold the stage in
// ex_divider until its DONE state. SRAM requests are gated by MEM_allow_in
// so a load/store issues only on the handoff cycle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
)(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ID_to_EX_valid,
  input  logic [TO_EX_DATA_WIDTH-1:0]  to_EX_data,
  output logic                         EX_allow_in,
  input  logic                         MEM_allow_in,
  output logic                         EX_to_MEM_valid,
  output logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data,
  output logic                         data_sram_en,
  output logic [3:0]                   data_sram_we,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata,
  output logic [FORWRD_DATA_WIDTH-1:0] EX_forward,
  output logic                         EX_fwd_block
);

  logic        ex_valid_q, ex_valid_d;
  ex_bundle_t  bundle_q, bundle_d;
  mem_bundle_t mem_bundle_s;

  logic        is_div_s;
  logic        is_mod_s;
  logic        div_signed_s;
  logic        ex_ready_go_s;
  logic        div_start_s;
  logic        div_ack_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] alu_result_s;
  logic [31:0] quotient_s;
  logic [31:0] remainder_s;
  logic [31:0] ex_result_s;

  alu u_alu (
    .alu_op     (bundle_q.alu_op),
    .alu_src1   (bundle_q.src1),
    .alu_src2   (bundle_q.src2),
    .alu_result (alu_result_s)
  );

  ex_divider #(
    .DIV_ITER (DIV_ITER)
  ) u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start_s),
    .is_signed (div_signed_s),
    .dividend  (bundle_q.src1),
    .divisor   (bundle_q.src2),
    .ack       (div_ack_s),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (quotient_s),
    .remainder (remainder_s)
  );

  // Divide decode, handshake and result selection
  always_comb begin
    is_div_s        = |bundle_q.div_op;
    is_mod_s        = bundle_q.div_op[MOD_W] | bundle_q.div_op[MOD_WU];
    div_signed_s    = bundle_q.div_op[DIV_W] | bundle_q.div_op[MOD_W];
    ex_ready_go_s   = ~is_div_s | div_done_s;
    EX_allow_in     = ~ex_valid_q | (ex_ready_go_s & MEM_allow_in);
    EX_to_MEM_valid = ex_valid_q & ex_ready_go_s;
    // Start only from IDLE; the divider also ignores start elsewhere.
    div_start_s     = ex_valid_q & is_div_s & ~div_busy_s & ~div_done_s;
    div_ack_s       = EX_to_MEM_valid & MEM_allow_in;
    if (is_div_s) begin
      if (is_mod_s) begin
        ex_result_s = remainder_s;
      end else begin
        ex_result_s = quotient_s;
      end
    end else begin
      ex_result_s = alu_result_s;
    end
  end

  // Output bundle, SRAM request and forwarding information
  always_comb begin
    mem_bundle_s.pc           = bundle_q.pc;
    mem_bundle_s.alu_result   = ex_result_s;
    mem_bundle_s.res_from_mem = bundle_q.res_from_mem;
    mem_bundle_s.dest         = bundle_q.dest;
    mem_bundle_s.gr_we        = bundle_q.gr_we;
    to_MEM_data     = mem_bundle_s;
    data_sram_en    = ex_valid_q & (bundle_q.res_from_mem | bundle_q.mem_we) & MEM_allow_in;
    data_sram_we    = {4{ex_valid_q & bundle_q.mem_we & MEM_allow_in}};
    data_sram_addr  = alu_result_s;
    data_sram_wdata = bundle_q.rkd_value;
    EX_forward      = {bundle_q.dest & {5{ex_valid_q & bundle_q.gr_we}}, ex_result_s};
    EX_fwd_block    = ex_valid_q & (bundle_q.res_from_mem | (is_div_s & ~div_done_s));
  end

  // Next valid and bundle values
  always_comb begin
    ex_valid_d = ex_valid_q;
    bundle_d   = bundle_q;
    if (EX_allow_in) begin
      ex_valid_d = ID_to_EX_valid;
    end else begin
      ex_valid_d = ex_valid_q;
    end
    if (ID_to_EX_valid & EX_allow_in) begin
      bundle_d = to_EX_data;
    end else begin
      bundle_d = bundle_q;
    end
  end

  // Stage valid and bundle registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= 1'b0;
      bundle_q   <= ex_bundle_t'({TO_EX_DATA_WIDTH{1'b0}});
    end else begin
      ex_valid_q <= ex_valid_d;
      bundle_q   <= bundle_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized bench for ex_stage. A transaction-level
// model (bundle in EX plus its age) predicts every output on each falling edge.
module tb_ex_stage;

  localparam int DIV_ITER = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ID_to_EX_valid = 1'b0;
  logic [151:0] to_EX_data = '0;
  logic         MEM_allow_in = 1'b1;
  logic         EX_allow_in;
  logic         EX_to_MEM_valid;
  logic [70:0]  to_MEM_data;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [36:0]  EX_forward;
  logic         EX_fwd_block;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.DIV_ITER(DIV_ITER)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ID_to_EX_valid  (ID_to_EX_valid),
    .to_EX_data      (to_EX_data),
    .EX_allow_in     (EX_allow_in),
    .MEM_allow_in    (MEM_allow_in),
    .EX_to_MEM_valid (EX_to_MEM_valid),
    .to_MEM_data     (to_MEM_data),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .EX_forward      (EX_forward),
    .EX_fwd_block    (EX_fwd_block)
  );

  task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [151:0] mk(input logic [31:0] pc, input logic [11:0] aop,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [3:0] dop, input logic rfm, input logic mwe,
                                      input logic [31:0] rkd, input logic [4:0] dest,
                                      input logic gwe);
    return {pc, aop, s1, s2, dop, rfm, mwe, rkd, dest, gwe};
  endfunction

  // Architectural result of a bundle, straight from the instruction semantics.
  function automatic logic [31:0] ref_result(input logic [151:0] b);
    logic [11:0] op;
    logic [31:0] a, c;
    logic [3:0]  d;
    int sa, sc;
    op = b[119:108]; a = b[107:76]; c = b[75:44]; d = b[43:40];
    sa = a; sc = c;
    if (d != 4'd0) begin
      if (d[0] || d[1]) begin
        if (c == 32'd0) return d[0] ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && c == 32'hFFFF_FFFF) return d[0] ? 32'h8000_0000 : 32'd0;
        return d[0] ? 32'(sa / sc) : 32'(sa % sc);
      end else begin
        if (c == 32'd0) return d[2] ? 32'hFFFF_FFFF : a;
        return d[2] ? (a / c) : (a % c);
      end
    end
    case (1'b1)
      op[0]:   return a + c;
      op[1]:   return a - c;
      op[2]:   return (sa < sc) ? 32'd1 : 32'd0;
      op[3]:   return (a < c) ? 32'd1 : 32'd0;
      op[4]:   return a & c;
      op[5]:   return ~(a | c);
      op[6]:   return a | c;
      op[7]:   return a ^ c;
      op[8]:   return a << c[4:0];
      op[9]:   return a >> c[4:0];
      op[10]:  return 32'(sa >>> c[4:0]);
      op[11]:  return c;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [151:0] rand_bundle();
    int kind;
    logic [31:0] a, c, pc, rkd;
    logic [4:0]  dest;
    kind = $urandom_range(0, 9);
    a = pick_operand(); c = pick_operand();
    pc = $urandom; rkd = $urandom; dest = 5'($urandom_range(0, 31));
    if (kind <= 5)
      return mk(pc, 12'd1 << $urandom_range(0, 11), a, c, 4'd0, 1'b0, 1'b0, rkd, dest, 1'($urandom_range(0, 1)));
    else if (kind <= 7)
      return mk(pc, 12'd0, a, c, 4'd1 << $urandom_range(0, 3), 1'b0, 1'b0, rkd, dest, 1'b1);
    else if (kind == 8)
      return mk(pc, 12'd1, a, c, 4'd0, 1'b1, 1'b0, rkd, dest, 1'b1);
    else
      return mk(pc, 12'd1, a, c, 4'd0, 1'b0, 1'b1, rkd, dest, 1'b0);
  endfunction

  // Reference model: what sits in EX and how many cycles it has been there.
  logic [151:0] m_b = '0;
  bit           m_valid = 1'b0;
  int           m_age = 0;

  always @(negedge clk) begin : model
    logic div, ready, allow, tmv, rfm, mwe, gwe;
    logic [31:0] res;
    if (!resetn) begin
      m_valid = 1'b0;
      m_age   = 0;
      chk("rst_to_mem_valid", EX_to_MEM_valid, 1'b0);
      chk("rst_allow_in", EX_allow_in, 1'b1);
      chk("rst_sram_en", data_sram_en, 1'b0);
      chk("rst_sram_we", data_sram_we, 4'h0);
      chk("rst_fwd_block", EX_fwd_block, 1'b0);
      chk("rst_fwd_dest", EX_forward[36:32], 5'd0);
    end else begin
      div   = (m_b[43:40] != 4'd0);
      rfm   = m_b[39]; mwe = m_b[38]; gwe = m_b[0];
      ready = !div || (m_age >= DIV_ITER + 1);
      allow = !m_valid || (ready && MEM_allow_in);
      tmv   = m_valid && ready;
      res   = ref_result(m_b);
      chk("m_allow_in", EX_allow_in, allow);
      chk("m_to_mem_valid", EX_to_MEM_valid, tmv);
      if (tmv) begin
        chk("m_to_mem_data", to_MEM_data, {m_b[151:120], res, rfm, m_b[5:1], gwe});
        chk("m_fwd_result", EX_forward[31:0], res);
      end
      chk("m_fwd_dest", EX_forward[36:32], (m_valid && gwe) ? m_b[5:1] : 5'd0);
      chk("m_fwd_block", EX_fwd_block, m_valid && (rfm || (div && !ready)));
      chk("m_sram_en", data_sram_en, m_valid && (rfm || mwe) && MEM_allow_in);
      chk("m_sram_we", data_sram_we, {4{m_valid && mwe && MEM_allow_in}});
      if (m_valid && (rfm || mwe)) begin
        chk("m_sram_addr", data_sram_addr, res);
        chk("m_sram_wdata", data_sram_wdata, m_b[37:6]);
      end
      if (allow) begin
        m_valid = ID_to_EX_valid;
        if (ID_to_EX_valid) begin
          m_b   = to_EX_data;
          m_age = 0;
        end
      end else begin
        m_age++;
      end
    end
  end

  // Present a bundle from ID and hold it until EX takes it.
  task automatic issue(input logic [151:0] b);
    int n;
    n = 0;
    ID_to_EX_valid = 1'b1;
    to_EX_data     = b;
    @(negedge clk);
    while (!EX_allow_in && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("issue_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    ID_to_EX_valid = 1'b0;
  endtask

  task automatic run_div(input string name, input logic [3:0] dop, input logic [31:0] a,
                         input logic [31:0] c, input logic [31:0] exp);
    int n;
    n = 0;
    issue(mk(32'h1c00_0100, 12'd0, a, c, dop, 1'b0, 1'b0, 32'd0, 5'd7, 1'b1));
    @(negedge clk);
    while (!EX_allow_in && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, n, DIV_ITER + 1);
    chk({name, "_result"}, to_MEM_data[38:7], exp);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    bit accepted;
    @(negedge clk);
    chk("reset_allow_in", EX_allow_in, 1'b1);
    chk("reset_valid", EX_to_MEM_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // add 5 + 7
    issue(mk(32'h1c00_0000, 12'h001, 32'd5, 32'd7, 4'd0, 1'b0, 1'b0, 32'd0, 5'd3, 1'b1));
    @(negedge clk);
    chk("add_valid", EX_to_MEM_valid, 1'b1);
    chk("add_result", to_MEM_data[38:7], 32'd12);
    chk("add_forward", EX_forward, {5'd3, 32'd12});
    chk("add_fwd_block", EX_fwd_block, 1'b0);
    @(posedge clk);
    #1;

    // divides: signed, unsigned, divide by zero, overflow
    run_div("div_w",       4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod_w",       4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div_wu_zero", 4'b0100, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_div("mod_wu_zero", 4'b1000, 32'h0000_1234, 32'd0, 32'h0000_1234);
    run_div("div_w_ovf",   4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod_w_ovf",   4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div_wu",      4'b0100, 32'd100, 32'd7, 32'd14);

    // store held back by MEM for three cycles
    MEM_allow_in = 1'b0;
    issue(mk(32'h1c00_0200, 12'h001, 32'h100, 32'd0, 4'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0));
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_sram_we == 4'hF) begin
        cnt++;
        chk("store_addr", data_sram_addr, 32'h100);
        chk("store_wdata", data_sram_wdata, 32'hDEAD_BEEF);
      end
      if (i == 2) begin
        @(posedge clk);
        #1 MEM_allow_in = 1'b1;
      end
    end
    chk("store_we_cycles", cnt, 1);
    @(posedge clk);
    #1;

    // load stalled by MEM: forwarding blocked, bundle held, no request
    MEM_allow_in = 1'b0;
    issue(mk(32'h1c00_0300, 12'h001, 32'h200, 32'h4, 4'd0, 1'b1, 1'b0, 32'd0, 5'd4, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("load_fwd_block", EX_fwd_block, 1'b1);
      chk("load_fwd_dest", EX_forward[36:32], 5'd4);
      chk("load_sram_en", data_sram_en, 1'b0);
      chk("load_hold", to_MEM_data, {32'h1c00_0300, 32'h204, 1'b1, 5'd4, 1'b1});
    end
    @(posedge clk);
    #1 MEM_allow_in = 1'b1;
    @(negedge clk);
    chk("load_sram_en_go", data_sram_en, 1'b1);
    chk("load_sram_we_go", data_sram_we, 4'h0);
    @(posedge clk);
    #1;

    // reset in the middle of a divide
    issue(mk(32'h1c00_0400, 12'd0, 32'd1000, 32'd3, 4'b0001, 1'b0, 1'b0, 32'd0, 5'd9, 1'b1));
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_valid", EX_to_MEM_valid, 1'b0);
    chk("midrst_allow_in", EX_allow_in, 1'b1);
    chk("midrst_fwd_block", EX_fwd_block, 1'b0);
    chk("midrst_sram_en", data_sram_en, 1'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    issue(mk(32'h1c00_0500, 12'h001, 32'd100, 32'd23, 4'd0, 1'b0, 1'b0, 32'd0, 5'd5, 1'b1));
    @(negedge clk);
    chk("post_rst_add_valid", EX_to_MEM_valid, 1'b1);
    chk("post_rst_add_result", to_MEM_data[38:7], 32'd123);
    @(posedge clk);
    #1;

    // randomized traffic with random back-pressure and one reset pulse
    accepted = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (!ID_to_EX_valid || accepted) begin
        ID_to_EX_valid = ($urandom_range(0, 3) != 0);
        to_EX_data     = rand_bundle();
      end
      MEM_allow_in = ($urandom_range(0, 3) != 0);
      if (cyc == 1200) resetn = 1'b0;
      if (cyc == 1201) resetn = 1'b1;
      @(negedge clk);
      accepted = EX_allow_in && ID_to_EX_valid;
      @(posedge clk);
      #1;
    end
    ID_to_EX_valid = 1'b0;
    MEM_allow_in   = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
